branch_resolve_queue: RTL and testbench

In-order tracking queue that records each fetch-time branch prediction and checks it against the execute-stage outcome. It sits between fetch (the producer of predictions from the two-bit predictor table) and execute (branch resolution). For every resolved branch it drives the training update back to the predictor table. On a wrong prediction it raises a mispredict redirect and flushes every younger in-flight entry.

---
 rtl/branch_resolve_queue_if.sv | 53 +++++
 rtl/branch_resolve_queue.sv | 125 ++++++++++++
 tb/tb_branch_resolve_queue.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/branch_resolve_queue_if.sv
// Purpose: signal bundle between the branch resolve queue and its fetch /
//          execute neighbours. The master side (fetch + execute) drives the
//          prediction pushes and resolutions. The slave side (the queue)
//          returns the push handshake, predictor training, redirect and status.
// Ports (interface members):
//   pred_valid/pred_ready/pred_taken/pred_index/pred_target/pred_fallthru
//     - fetch push of one predicted branch
//   res_valid/res_taken/res_target
//     - execute resolution of the oldest branch
//   upd_valid/upd_index/upd_taken
//     - one-cycle training pulse to the predictor table
//   mispredict/redirect_pc
//     - one-cycle redirect pulse and the correct next PC
//   count/err_underflow
//     - occupancy and the empty-resolve error pulse
interface branch_resolve_queue_if #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int IDX_W = 6
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             pred_valid;
  logic             pred_ready;
  logic             pred_taken;
  logic [IDX_W-1:0] pred_index;
  logic [PC_W-1:0]  pred_target;
  logic [PC_W-1:0]  pred_fallthru;
  logic             res_valid;
  logic             res_taken;
  logic [PC_W-1:0]  res_target;
  logic             upd_valid;
  logic [IDX_W-1:0] upd_index;
  logic             upd_taken;
  logic             mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [CNT_W-1:0] count;
  logic             err_underflow;

  modport master (
    output pred_valid, pred_taken, pred_index, pred_target, pred_fallthru,
    output res_valid, res_taken, res_target,
    input  pred_ready, upd_valid, upd_index, upd_taken,
    input  mispredict, redirect_pc, count, err_underflow
  );

  modport slave (
    input  pred_valid, pred_taken, pred_index, pred_target, pred_fallthru,
    input  res_valid, res_taken, res_target,
    output pred_ready, upd_valid, upd_index, upd_taken,
    output mispredict, redirect_pc, count, err_underflow
  );
endinterface

// File: rtl/branch_resolve_queue.sv
// Purpose: in-order queue of fetch-time branch predictions. Each execute
//          resolution is checked against the oldest entry. The queue emits a
//          registered training update for the predictor. On a wrong
//          prediction it emits a redirect and flushes every younger entry.
// Ports:
//   clk   - clock
//   reset - synchronous, active-high reset
//   bus   - branch_resolve_queue_if slave modport (push, resolve, update,
//           redirect, count, underflow error)
module branch_resolve_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32,
  parameter int IDX_W = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  branch_resolve_queue_if.slave  bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Entry storage. It has no reset because occupancy is tracked by r_count.
  logic             r_taken    [DEPTH];
  logic [IDX_W-1:0] r_index    [DEPTH];
  logic [PC_W-1:0]  r_target   [DEPTH];
  logic [PC_W-1:0]  r_fallthru [DEPTH];

  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  logic             r_upd_valid;
  logic [IDX_W-1:0] r_upd_index;
  logic             r_upd_taken;
  logic             r_mispredict;
  logic [PC_W-1:0]  r_redirect_pc;
  logic             r_err_underflow;

  logic w_ready;
  logic w_push;
  logic w_resolve;
  logic w_underflow;
  logic w_wrong;
  logic w_flush;
  logic w_pop;

  // Push is refused in the redirect cycle so that wrong-path fetches never enter.
  assign w_ready     = !reset && (r_count < CNT_W'(DEPTH)) && !r_mispredict;
  assign w_push      = bus.pred_valid && w_ready;
  assign w_resolve   = bus.res_valid && (r_count != '0);
  assign w_underflow = bus.res_valid && (r_count == '0);

  // A taken/taken pair still mispredicts if the predicted target was wrong.
  assign w_wrong = (bus.res_taken != r_taken[r_head]) ||
                   (bus.res_taken && r_taken[r_head] &&
                    (bus.res_target != r_target[r_head]));
  assign w_flush = w_resolve && w_wrong;
  assign w_pop   = w_resolve && !w_wrong;

  // Entries are written at the tail. A push that coincides with a flush is
  // wrong-path and is dropped.
  always_ff @(posedge clk) begin
    if (w_push && !w_flush) begin
      r_taken[r_tail]    <= bus.pred_taken;
      r_index[r_tail]    <= bus.pred_index;
      r_target[r_tail]   <= bus.pred_target;
      r_fallthru[r_tail] <= bus.pred_fallthru;
    end
  end

  // The pointers wrap for free because DEPTH is a power of two. A flush
  // empties the queue outright instead of walking the pointers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Training, redirect and error outputs are registered one-cycle pulses.
  // The index, direction and redirect PC hold between pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_upd_valid     <= 1'b0;
      r_upd_index     <= '0;
      r_upd_taken     <= 1'b0;
      r_mispredict    <= 1'b0;
      r_redirect_pc   <= '0;
      r_err_underflow <= 1'b0;
    end else begin
      r_upd_valid     <= w_resolve;
      r_mispredict    <= w_flush;
      r_err_underflow <= w_underflow;
      if (w_resolve) begin
        r_upd_index <= r_index[r_head];
        r_upd_taken <= bus.res_taken;
      end
      if (w_flush) begin
        r_redirect_pc <= bus.res_taken ? bus.res_target : r_fallthru[r_head];
      end
    end
  end

  assign bus.pred_ready    = w_ready;
  assign bus.upd_valid     = r_upd_valid;
  assign bus.upd_index     = r_upd_index;
  assign bus.upd_taken     = r_upd_taken;
  assign bus.mispredict    = r_mispredict;
  assign bus.redirect_pc   = r_redirect_pc;
  assign bus.count         = r_count;
  assign bus.err_underflow = r_err_underflow;
endmodule

// File: tb/tb_branch_resolve_queue.sv
// Purpose: self-checking bench for branch_resolve_queue. It uses directed
//          scenarios plus a randomized run. All of them are compared against a
//          queue-based reference model of the branch tracking rules.
// Ports: none (top-level bench).
module tb_branch_resolve_queue;
  localparam int DEPTH = 8;
  localparam int PC_W  = 32;
  localparam int IDX_W = 6;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int OBS_W = 4 + CNT_W + PC_W;

  logic clk = 1'b0;
  logic reset = 1'b1;

  branch_resolve_queue_if #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W)) bus ();

  branch_resolve_queue #(.DEPTH(DEPTH), .PC_W(PC_W), .IDX_W(IDX_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit             taken;
    bit [IDX_W-1:0] index;
    bit [PC_W-1:0]  target;
    bit [PC_W-1:0]  fallthru;
  } entry_t;

  // Reference model state: outstanding branches in program order, plus the
  // registered outputs expected after the most recent edge.
  entry_t         mQ[$];
  bit             expUpdValid;
  bit [IDX_W-1:0] expUpdIndex;
  bit             expUpdTaken;
  bit             expMisp;
  bit [PC_W-1:0]  expRedirect;
  bit             expUnder;

  int total = 0;
  int bad = 0;

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic modelEdge();
    entry_t h;
    entry_t n;
    bit doPush;
    bit wrong;
    bit newMisp;
    if (reset) begin
      mQ.delete();
      expUpdValid = 0; expUpdIndex = 0; expUpdTaken = 0;
      expMisp = 0; expRedirect = 0; expUnder = 0;
      return;
    end
    doPush = bus.pred_valid && (mQ.size() < DEPTH) && !expMisp;
    expUnder = bus.res_valid && (mQ.size() == 0);
    expUpdValid = 0;
    newMisp = 0;
    if (bus.res_valid && mQ.size() > 0) begin
      h = mQ[0];
      wrong = (bus.res_taken != h.taken) ||
              (bus.res_taken && h.taken && bus.res_target != h.target);
      expUpdValid = 1;
      expUpdIndex = h.index;
      expUpdTaken = bus.res_taken;
      if (wrong) begin
        newMisp = 1;
        expRedirect = bus.res_taken ? bus.res_target : h.fallthru;
        mQ.delete();
        doPush = 0;
      end else begin
        void'(mQ.pop_front());
      end
    end
    expMisp = newMisp;
    if (doPush) begin
      n.taken = bus.pred_taken; n.index = bus.pred_index;
      n.target = bus.pred_target; n.fallthru = bus.pred_fallthru;
      mQ.push_back(n);
    end
  endtask

  task automatic cycle();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  task automatic setPush(input bit v, input bit t, input bit [IDX_W-1:0] idx,
                         input bit [PC_W-1:0] tg, input bit [PC_W-1:0] fa);
    bus.pred_valid = v; bus.pred_taken = t; bus.pred_index = idx;
    bus.pred_target = tg; bus.pred_fallthru = fa;
  endtask

  task automatic setRes(input bit v, input bit t, input bit [PC_W-1:0] tg);
    bus.res_valid = v; bus.res_taken = t; bus.res_target = tg;
  endtask

  function automatic logic [OBS_W-1:0] observed();
    return {bus.pred_ready, bus.count, bus.upd_valid, bus.mispredict,
            bus.err_underflow, bus.redirect_pc};
  endfunction

  function automatic logic [OBS_W-1:0] expected();
    logic rdy;
    rdy = !reset && (mQ.size() < DEPTH) && !expMisp;
    return {rdy, CNT_W'(mQ.size()), expUpdValid, expMisp, expUnder, expRedirect};
  endfunction

  task automatic test_reset();
    setPush(0, 0, 0, 0, 0);
    setRes(0, 0, 0);
    reset = 1;
    cycle();
    cycle();
    total++;
    if (observed() !== {1'b0, CNT_W'(0), 3'b000, {PC_W{1'b0}}}) begin
      bad++; $display("[TB] FAIL reset_state: got %h want %h", observed(), {1'b0, CNT_W'(0), 3'b000, {PC_W{1'b0}}});
    end
    total++;
    if ({bus.upd_index, bus.upd_taken} !== '0) begin
      bad++; $display("[TB] FAIL reset_upd: got %h want 0", {bus.upd_index, bus.upd_taken});
    end
    reset = 0;
    #1;
    total++;
    if (bus.pred_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_ready: got %b want 1", bus.pred_ready);
    end
  endtask

  task automatic test_not_taken();
    for (int k = 1; k <= 3; k++) begin
      setPush(1, 0, IDX_W'(k), 32'h1000 + k, 32'h2000 + k);
      cycle();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("[TB] FAIL nt_push %0d: got %h want %h", k, observed(), expected());
      end
    end
    setPush(0, 0, 0, 0, 0);
    for (int k = 1; k <= 3; k++) begin
      setRes(1, 0, 0);
      cycle();
      total++;
      if ({bus.upd_valid, bus.upd_index, bus.upd_taken, bus.mispredict} !== {1'b1, IDX_W'(k), 1'b0, 1'b0}) begin
        bad++; $display("[TB] FAIL nt_resolve %0d: got %h want %h", k,
          {bus.upd_valid, bus.upd_index, bus.upd_taken, bus.mispredict}, {1'b1, IDX_W'(k), 1'b0, 1'b0});
      end
    end
    setRes(0, 0, 0);
    cycle();
    total++;
    if (bus.count !== CNT_W'(0) || bus.upd_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL nt_drained: got count=%0d upd=%b want 0 0", bus.count, bus.upd_valid);
    end
  endtask

  task automatic test_mispredict_dir();
    setPush(1, 1, 6'd5, 32'h100, 32'h44);
    cycle();
    setPush(0, 0, 0, 0, 0);
    setRes(1, 0, 0);
    cycle();
    total++;
    if ({bus.mispredict, bus.redirect_pc, bus.upd_taken, bus.count} !== {1'b1, 32'h44, 1'b0, CNT_W'(0)}) begin
      bad++; $display("[TB] FAIL misp_dir: got %h want %h",
        {bus.mispredict, bus.redirect_pc, bus.upd_taken, bus.count}, {1'b1, 32'h44, 1'b0, CNT_W'(0)});
    end
    setRes(0, 0, 0);
    cycle();
    total++;
    if (observed() !== expected()) begin
      bad++; $display("[TB] FAIL misp_dir_after: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_mispredict_target();
    setPush(1, 1, 6'd7, 32'h100, 32'h104);
    cycle();
    for (int k = 0; k < 4; k++) begin
      setPush(1, 0, IDX_W'(8 + k), 32'h300 + k, 32'h400 + k);
      cycle();
    end
    total++;
    if (bus.count !== CNT_W'(5)) begin
      bad++; $display("[TB] FAIL tgt_fill: got count=%0d want 5", bus.count);
    end
    setPush(1, 0, 6'd12, 32'h500, 32'h504);
    setRes(1, 1, 32'h200);
    cycle();
    total++;
    if ({bus.mispredict, bus.redirect_pc, bus.count, bus.pred_ready, bus.upd_index} !==
        {1'b1, 32'h200, CNT_W'(0), 1'b0, 6'd7}) begin
      bad++; $display("[TB] FAIL misp_target: got %h want %h",
        {bus.mispredict, bus.redirect_pc, bus.count, bus.pred_ready, bus.upd_index},
        {1'b1, 32'h200, CNT_W'(0), 1'b0, 6'd7});
    end
    setRes(0, 0, 0);
    cycle();
    total++;
    if (bus.count !== CNT_W'(0) || observed() !== expected()) begin
      bad++; $display("[TB] FAIL misp_refuse: got %h want %h", observed(), expected());
    end
    setPush(0, 0, 0, 0, 0);
    cycle();
  endtask

  task automatic test_full_wrap();
    for (int k = 0; k < DEPTH; k++) begin
      setPush(1, 1'($urandom_range(0, 1)), IDX_W'(16 + k), $urandom, $urandom);
      cycle();
    end
    total++;
    if ({bus.pred_ready, bus.count} !== {1'b0, CNT_W'(DEPTH)}) begin
      bad++; $display("[TB] FAIL full: got %h want %h", {bus.pred_ready, bus.count}, {1'b0, CNT_W'(DEPTH)});
    end
    setPush(1, 0, 6'h3f, 32'h0, 32'h4);
    setRes(1, mQ[0].taken, mQ[0].target);
    cycle();
    total++;
    if (bus.count !== CNT_W'(DEPTH - 1) || bus.mispredict !== 1'b0) begin
      bad++; $display("[TB] FAIL full_pushpop: got count=%0d misp=%b want 7 0", bus.count, bus.mispredict);
    end
    for (int k = 0; k < 20 + DEPTH - 1; k++) begin
      if (k < 20) setPush(1, 1'($urandom_range(0, 1)), IDX_W'(k), $urandom, $urandom);
      else setPush(0, 0, 0, 0, 0);
      setRes(1, mQ[0].taken, mQ[0].target);
      cycle();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("[TB] FAIL wrap %0d: got %h want %h", k, observed(), expected());
      end
      if (expUpdValid) begin
        total++;
        if ({bus.upd_index, bus.upd_taken} !== {expUpdIndex, expUpdTaken}) begin
          bad++; $display("[TB] FAIL wrap_upd %0d: got %h want %h", k, {bus.upd_index, bus.upd_taken}, {expUpdIndex, expUpdTaken});
        end
      end
    end
    setPush(0, 0, 0, 0, 0);
    setRes(0, 0, 0);
    cycle();
  endtask

  task automatic test_underflow();
    setPush(1, 0, 6'h2a, 32'h600, 32'h604);
    setRes(1, 0, 0);
    cycle();
    total++;
    if ({bus.err_underflow, bus.upd_valid, bus.count} !== {1'b1, 1'b0, CNT_W'(1)}) begin
      bad++; $display("[TB] FAIL underflow: got %h want %h", {bus.err_underflow, bus.upd_valid, bus.count}, {1'b1, 1'b0, CNT_W'(1)});
    end
    setPush(0, 0, 0, 0, 0);
    setRes(0, 0, 0);
    cycle();
    total++;
    if (bus.err_underflow !== 1'b0) begin
      bad++; $display("[TB] FAIL underflow_pulse: got %b want 0", bus.err_underflow);
    end
    setRes(1, 0, 0);
    cycle();
    setRes(0, 0, 0);
    cycle();
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 4; k++) begin
      setPush(1, 1, IDX_W'(40 + k), 32'h700 + k, 32'h800 + k);
      cycle();
    end
    reset = 1;
    setRes(1, 0, 0);
    cycle();
    total++;
    if ({observed(), bus.upd_index, bus.upd_taken} !== '0) begin
      bad++; $display("[TB] FAIL reset_mid: got %h want 0", {observed(), bus.upd_index, bus.upd_taken});
    end
    reset = 0;
    setPush(0, 0, 0, 0, 0);
    setRes(0, 0, 0);
    #1;
    total++;
    if (bus.pred_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL reset_mid_ready: got %b want 1", bus.pred_ready);
    end
    cycle();
    total++;
    if (observed() !== expected() || bus.upd_valid !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_mid_after: got %h want %h", observed(), expected());
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      setPush(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), IDX_W'($urandom),
              32'($urandom_range(0, 3)) << 4, $urandom);
      if (mQ.size() > 0 && $urandom_range(0, 4) != 0)
        setRes(1'($urandom_range(0, 2) != 0), mQ[0].taken, mQ[0].target);
      else
        setRes(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 3)) << 4);
      cycle();
      total++;
      if (observed() !== expected()) begin
        bad++; $display("[TB] FAIL random %0d: got %h want %h", k, observed(), expected());
      end
      if (expUpdValid) begin
        total++;
        if ({bus.upd_index, bus.upd_taken} !== {expUpdIndex, expUpdTaken}) begin
          bad++; $display("[TB] FAIL random_upd %0d: got %h want %h", k, {bus.upd_index, bus.upd_taken}, {expUpdIndex, expUpdTaken});
        end
      end
    end
    setPush(0, 0, 0, 0, 0);
    setRes(0, 0, 0);
  endtask

  initial begin
    $display("[TB] branch_resolve_queue bench start");
    test_reset();
    test_not_taken();
    test_mispredict_dir();
    test_mispredict_target();
    test_full_wrap();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
